// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over a req/valid handshake,
// holds the instruction for decode and computes the next PC on retire.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_RData,
  input  logic        IMem_Valid,
  input  logic        Stall,
  input  logic        Retire,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Retired_Count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] retired_q;
  logic            valid_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] next_pc;
  logic            fetch_fire;
  logic            retire_fire;

  // Stall gates the request in the same cycle, so a response seen while stalled is dropped.
  assign fetch_fire  = (state == FETCH) && !Stall && IMem_Valid;
  assign retire_fire = (state == EXEC) && Retire && !Stall;

  assign pc_plus4   = pc_q + XLEN'(4);
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump wins over a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (Branch && Zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (fetch_fire) begin
            instr_q <= IMem_RData;
            valid_q <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (retire_fire) begin
            pc_q      <= next_pc;
            valid_q   <= 1'b0;
            retired_q <= retired_q + XLEN'(1);
            state     <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign IMem_Req      = (state == FETCH) && !Stall;
  assign IMem_Addr     = pc_q;
  assign Instr         = instr_q;
  assign Instr_Valid   = valid_q;
  assign Opcode        = instr_q[31:26];
  assign Funct         = instr_q[5:0];
  assign PC            = pc_q;
  assign PCPlus4       = pc_plus4;
  assign Retired_Count = retired_q;

endmodule
